// File: rtl/bp_update_scheduler.sv
// Branch predictor table write scheduler: post-reset init sweep, tag/target and
// outcome update queues, arbitration and BHT read-modify-write with forwarding.
module bp_update_scheduler #(
  parameter int BRANCH_PREDICTOR = 1,
  parameter int BTB_IDX_SIZE     = 4,
  parameter int QUEUE_DEPTH      = 2,
  parameter int STARVE_LIMIT     = 4,
  parameter int WORD_SIZE        = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tag_req,
  input  logic [WORD_SIZE-1:0]              tag_pc,
  input  logic [WORD_SIZE-1:0]              tag_target,
  input  logic                              bht_req,
  input  logic [WORD_SIZE-1:0]              bht_pc,
  input  logic                              bht_taken,
  output logic [BTB_IDX_SIZE-1:0]           rd_idx,
  input  logic [1:0]                        rd_bht,
  output logic                              wr_en,
  output logic [BTB_IDX_SIZE-1:0]           wr_idx,
  output logic                              wr_tag_en,
  output logic [WORD_SIZE-BTB_IDX_SIZE-1:0] wr_tag,
  output logic [WORD_SIZE-1:0]              wr_target,
  output logic                              wr_bht_en,
  output logic [1:0]                        wr_bht,
  output logic                              stall,
  output logic                              init_busy,
  output logic                              overflow
);

  localparam int TAG_W = WORD_SIZE - BTB_IDX_SIZE;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [BTB_IDX_SIZE-1:0] sweep_q, sweep_d;
  logic [PTR_W-1:0]        tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
  logic [PTR_W-1:0]        bht_wr_ptr_q, bht_wr_ptr_d, bht_rd_ptr_q, bht_rd_ptr_d;
  logic [CNT_W-1:0]        tag_cnt_q, tag_cnt_d, bht_cnt_q, bht_cnt_d;
  logic [STV_W-1:0]        starve_q, starve_d;
  logic                    overflow_q, overflow_d, init_busy_q, init_busy_d;
  logic                    wr_en_q, wr_en_d, wr_tag_en_q, wr_tag_en_d, wr_bht_en_q, wr_bht_en_d;
  logic [BTB_IDX_SIZE-1:0] wr_idx_q, wr_idx_d;
  logic [TAG_W-1:0]        wr_tag_q, wr_tag_d;
  logic [WORD_SIZE-1:0]    wr_target_q, wr_target_d;
  logic [1:0]              wr_bht_q, wr_bht_d;

  logic [WORD_SIZE-1:0]    tag_pc_mem_q  [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0]    tag_tgt_mem_q [QUEUE_DEPTH];
  logic [BTB_IDX_SIZE-1:0] bht_idx_mem_q [QUEUE_DEPTH];
  logic                    bht_tkn_mem_q [QUEUE_DEPTH];

  logic                    tag_full, tag_empty, bht_full, bht_empty;
  logic                    tag_win, bht_win, tag_push, bht_push;
  logic [WORD_SIZE-1:0]    tag_head_pc;
  logic [1:0]              old_ctr;
  logic                    unused_bht_pc_hi;

  assign unused_bht_pc_hi = ^bht_pc[WORD_SIZE-1:BTB_IDX_SIZE];

  function automatic logic [1:0] next_ctr(input logic [1:0] old, input logic taken);
    logic [1:0] nxt;
    if (BRANCH_PREDICTOR == 2) begin
      // Hysteresis: a single contrary outcome from a strong state only weakens it.
      if (taken) nxt = (old == 2'b00) ? 2'b01 : 2'b11;
      else       nxt = (old == 2'b11) ? 2'b10 : 2'b00;
    end else begin
      if (taken) nxt = (old == 2'b11) ? old : old + 2'b01;
      else       nxt = (old == 2'b00) ? old : old - 2'b01;
    end
    return nxt;
  endfunction

  assign tag_full    = (tag_cnt_q == CNT_W'(QUEUE_DEPTH));
  assign bht_full    = (bht_cnt_q == CNT_W'(QUEUE_DEPTH));
  assign tag_empty   = (tag_cnt_q == '0);
  assign bht_empty   = (bht_cnt_q == '0);
  assign tag_head_pc = tag_pc_mem_q[tag_rd_ptr_q];
  assign rd_idx      = bht_idx_mem_q[bht_rd_ptr_q];

  // The write still in flight has not reached the table yet, so it overrides rd_bht.
  assign old_ctr = (wr_en_q && wr_bht_en_q && (wr_idx_q == rd_idx)) ? wr_bht_q : rd_bht;

  assign tag_win  = (state_q == ST_RUN) && !tag_empty &&
                    (bht_empty || (starve_q == STV_W'(STARVE_LIMIT)));
  assign bht_win  = (state_q == ST_RUN) && !bht_empty && !tag_win;
  assign tag_push = tag_req && (!tag_full || tag_win);
  assign bht_push = bht_req && (!bht_full || bht_win);

  always_comb begin
    // NOTE: every *_d gets a default first so no path through this block infers a latch.
    state_d      = state_q;
    sweep_d      = sweep_q;
    starve_d     = starve_q;
    init_busy_d  = (state_q == ST_INIT);
    overflow_d   = overflow_q | (tag_req & !tag_push) | (bht_req & !bht_push);
    tag_wr_ptr_d = tag_push ? tag_wr_ptr_q + 1'b1 : tag_wr_ptr_q;
    tag_rd_ptr_d = tag_win  ? tag_rd_ptr_q + 1'b1 : tag_rd_ptr_q;
    bht_wr_ptr_d = bht_push ? bht_wr_ptr_q + 1'b1 : bht_wr_ptr_q;
    bht_rd_ptr_d = bht_win  ? bht_rd_ptr_q + 1'b1 : bht_rd_ptr_q;
    tag_cnt_d    = tag_cnt_q + CNT_W'(tag_push) - CNT_W'(tag_win);
    bht_cnt_d    = bht_cnt_q + CNT_W'(bht_push) - CNT_W'(bht_win);
    wr_en_d      = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_tag_en_d  = wr_tag_en_q;
    wr_tag_d     = wr_tag_q;
    wr_target_d  = wr_target_q;
    wr_bht_en_d  = wr_bht_en_q;
    wr_bht_d     = wr_bht_q;

    if (tag_empty || tag_win) starve_d = '0;
    else if (bht_win)         starve_d = starve_q + 1'b1;

    if (state_q == ST_INIT) begin
      wr_en_d     = 1'b1;
      wr_idx_d    = sweep_q;
      wr_tag_en_d = 1'b1;
      wr_tag_d    = '0;
      wr_target_d = '0;
      wr_bht_en_d = 1'b1;
      wr_bht_d    = 2'b10;
      sweep_d     = sweep_q + 1'b1;
      if (sweep_q == '1) state_d = ST_RUN;
    end else if (tag_win) begin
      wr_en_d     = 1'b1;
      wr_idx_d    = tag_head_pc[BTB_IDX_SIZE-1:0];
      wr_tag_en_d = 1'b1;
      wr_tag_d    = tag_head_pc[WORD_SIZE-1:BTB_IDX_SIZE];
      wr_target_d = tag_tgt_mem_q[tag_rd_ptr_q];
      wr_bht_en_d = 1'b0;
    end else if (bht_win && (BRANCH_PREDICTOR != 0)) begin
      wr_en_d     = 1'b1;
      wr_idx_d    = rd_idx;
      wr_tag_en_d = 1'b0;
      wr_bht_en_d = 1'b1;
      wr_bht_d    = next_ctr(old_ctr, bht_tkn_mem_q[bht_rd_ptr_q]);
    end
  end

  // NOTE: queue storage has no reset; validity is tracked solely by pointers and counts.
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_pc_mem_q[tag_wr_ptr_q]  <= tag_pc;
      tag_tgt_mem_q[tag_wr_ptr_q] <= tag_target;
    end
    if (bht_push) begin
      bht_idx_mem_q[bht_wr_ptr_q] <= bht_pc[BTB_IDX_SIZE-1:0];
      bht_tkn_mem_q[bht_wr_ptr_q] <= bht_taken;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      starve_q     <= '0;
      init_busy_q  <= 1'b1;
      overflow_q   <= 1'b0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      bht_wr_ptr_q <= '0;
      bht_rd_ptr_q <= '0;
      tag_cnt_q    <= '0;
      bht_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_tag_en_q  <= 1'b0;
      wr_tag_q     <= '0;
      wr_target_q  <= '0;
      wr_bht_en_q  <= 1'b0;
      wr_bht_q     <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      starve_q     <= starve_d;
      init_busy_q  <= init_busy_d;
      overflow_q   <= overflow_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      bht_wr_ptr_q <= bht_wr_ptr_d;
      bht_rd_ptr_q <= bht_rd_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
      bht_cnt_q    <= bht_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_tag_en_q  <= wr_tag_en_d;
      wr_tag_q     <= wr_tag_d;
      wr_target_q  <= wr_target_d;
      wr_bht_en_q  <= wr_bht_en_d;
      wr_bht_q     <= wr_bht_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_idx    = wr_idx_q;
  assign wr_tag_en = wr_tag_en_q;
  assign wr_tag    = wr_tag_q;
  assign wr_target = wr_target_q;
  assign wr_bht_en = wr_bht_en_q;
  assign wr_bht    = wr_bht_q;
  assign init_busy = init_busy_q;
  assign overflow  = overflow_q;
  assign stall     = init_busy_q | tag_full | bht_full;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: three instances (static, saturating,
// hysteresis) share stimulus; expected values are hand-derived constants.
module tb_bp_update_scheduler;

  localparam int IDX_W = 2;
  localparam int WS    = 16;
  localparam int TAG_W = WS - IDX_W;

  localparam logic       TAKEN [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [1:0] EXP1  [5] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01};
  localparam logic [1:0] EXP2  [5] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00};

  int checks = 0;
  int errors = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tag_req = 1'b0;
  logic [WS-1:0] tag_pc = '0;
  logic [WS-1:0] tag_target = '0;
  logic          bht_req = 1'b0;
  logic [WS-1:0] bht_pc = '0;
  logic          bht_taken = 1'b0;
  logic [1:0]    rd_bht1 = 2'b10;
  logic [1:0]    rd_bht2 = 2'b01;
  logic [1:0]    rd_bht0 = 2'b10;

  logic [IDX_W-1:0] rd_idx, wr_idx, h_rd_idx, h_wr_idx, s_rd_idx, s_wr_idx;
  logic             wr_en, wr_tag_en, wr_bht_en, stall, init_busy, overflow;
  logic             h_wr_en, h_wr_tag_en, h_wr_bht_en, h_stall, h_init_busy, h_overflow;
  logic             s_wr_en, s_wr_tag_en, s_wr_bht_en, s_stall, s_init_busy, s_overflow;
  logic [TAG_W-1:0] wr_tag, h_wr_tag, s_wr_tag;
  logic [WS-1:0]    wr_target, h_wr_target, s_wr_target;
  logic [1:0]       wr_bht, h_wr_bht, s_wr_bht;

  bp_update_scheduler #(.BRANCH_PREDICTOR(1), .BTB_IDX_SIZE(IDX_W), .QUEUE_DEPTH(2),
                        .STARVE_LIMIT(4), .WORD_SIZE(WS)) u_dut (
    .clk(clk), .reset(reset), .tag_req(tag_req), .tag_pc(tag_pc), .tag_target(tag_target),
    .bht_req(bht_req), .bht_pc(bht_pc), .bht_taken(bht_taken), .rd_idx(rd_idx),
    .rd_bht(rd_bht1), .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag_en(wr_tag_en), .wr_tag(wr_tag),
    .wr_target(wr_target), .wr_bht_en(wr_bht_en), .wr_bht(wr_bht), .stall(stall),
    .init_busy(init_busy), .overflow(overflow));

  bp_update_scheduler #(.BRANCH_PREDICTOR(2), .BTB_IDX_SIZE(IDX_W), .QUEUE_DEPTH(2),
                        .STARVE_LIMIT(4), .WORD_SIZE(WS)) u_dut_h (
    .clk(clk), .reset(reset), .tag_req(tag_req), .tag_pc(tag_pc), .tag_target(tag_target),
    .bht_req(bht_req), .bht_pc(bht_pc), .bht_taken(bht_taken), .rd_idx(h_rd_idx),
    .rd_bht(rd_bht2), .wr_en(h_wr_en), .wr_idx(h_wr_idx), .wr_tag_en(h_wr_tag_en),
    .wr_tag(h_wr_tag), .wr_target(h_wr_target), .wr_bht_en(h_wr_bht_en), .wr_bht(h_wr_bht),
    .stall(h_stall), .init_busy(h_init_busy), .overflow(h_overflow));

  bp_update_scheduler #(.BRANCH_PREDICTOR(0), .BTB_IDX_SIZE(IDX_W), .QUEUE_DEPTH(2),
                        .STARVE_LIMIT(4), .WORD_SIZE(WS)) u_dut_s (
    .clk(clk), .reset(reset), .tag_req(tag_req), .tag_pc(tag_pc), .tag_target(tag_target),
    .bht_req(bht_req), .bht_pc(bht_pc), .bht_taken(bht_taken), .rd_idx(s_rd_idx),
    .rd_bht(rd_bht0), .wr_en(s_wr_en), .wr_idx(s_wr_idx), .wr_tag_en(s_wr_tag_en),
    .wr_tag(s_wr_tag), .wr_target(s_wr_target), .wr_bht_en(s_wr_bht_en), .wr_bht(s_wr_bht),
    .stall(s_stall), .init_busy(s_init_busy), .overflow(s_overflow));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target, wr_bht, stall, init_busy, overflow}
        !== {3'b000, 2'd0, 14'd0, 16'd0, 2'd0, 3'b110}) begin
      errors++;
      $display("FAIL reset_values: got en/tag/bht=%b%b%b idx=%h stall=%b busy=%b ovf=%b, expected all 0 with stall=1 busy=1",
               wr_en, wr_tag_en, wr_bht_en, wr_idx, stall, init_busy, overflow);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target, wr_bht, init_busy}
          !== {3'b111, IDX_W'(k), 14'd0, 16'd0, 2'b10, 1'b1}) begin
        errors++;
        $display("FAIL sweep_%0d: got en=%b tagen=%b bhten=%b idx=%0d tag=%h tgt=%h bht=%b busy=%b, expected 1 1 1 %0d 0 0 10 1",
                 k, wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target, wr_bht, init_busy, k);
      end
    end
    step();
    checks++;
    if ({wr_en, init_busy, stall} !== 3'b000) begin
      errors++;
      $display("FAIL sweep_done: got en=%b busy=%b stall=%b, expected 0 0 0", wr_en, init_busy, stall);
    end
  endtask

  task automatic test_counter_modes();
    bht_req = 1'b1;
    bht_pc  = 16'h0005;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) bht_taken = TAKEN[i];
      else       bht_req = 1'b0;
      step();
      if (i == 0) begin
        checks++;
        if ({wr_en, rd_idx} !== {1'b0, 2'd1}) begin
          errors++;
          $display("FAIL mode_first: got en=%b rd_idx=%0d, expected 0 1", wr_en, rd_idx);
        end
      end else begin
        checks++;
        if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_bht} !== {3'b101, 2'd1, EXP1[i-1]}) begin
          errors++;
          $display("FAIL sat_update_%0d: got en=%b tagen=%b bhten=%b idx=%0d bht=%b, expected 1 0 1 1 %b",
                   i, wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_bht, EXP1[i-1]);
        end
        checks++;
        if ({h_wr_en, h_wr_bht_en, h_wr_bht} !== {2'b11, EXP2[i-1]}) begin
          errors++;
          $display("FAIL hyst_update_%0d: got en=%b bhten=%b bht=%b, expected 1 1 %b",
                   i, h_wr_en, h_wr_bht_en, h_wr_bht, EXP2[i-1]);
        end
        checks++;
        if (s_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL static_no_write_%0d: got en=%b, expected 0", i, s_wr_en);
        end
      end
    end
    step();
    checks++;
    if ({wr_en, h_wr_en, s_wr_en, s_stall} !== 4'b0000) begin
      errors++;
      $display("FAIL mode_idle: got en=%b h_en=%b s_en=%b s_stall=%b, expected 0 0 0 0",
               wr_en, h_wr_en, s_wr_en, s_stall);
    end
  endtask

  task automatic test_starvation();
    bht_req   = 1'b1;
    bht_pc    = 16'h0006;
    bht_taken = 1'b1;
    step();
    tag_req    = 1'b1;
    tag_pc     = 16'h0013;
    tag_target = 16'h0040;
    step();
    tag_req = 1'b0;
    for (int g = 0; g < 4; g++) begin
      step();
      checks++;
      if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, s_wr_en} !== {3'b101, 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL starve_bht_grant_%0d: got en=%b tagen=%b bhten=%b idx=%0d s_en=%b, expected 1 0 1 2 0",
                 g, wr_en, wr_tag_en, wr_bht_en, wr_idx, s_wr_en);
      end
    end
    step();
    checks++;
    if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target, stall}
        !== {3'b110, 2'd3, 14'h0004, 16'h0040, 1'b1}) begin
      errors++;
      $display("FAIL starve_tag_grant: got en=%b tagen=%b bhten=%b idx=%0d tag=%h tgt=%h stall=%b, expected 1 1 0 3 0004 0040 1",
               wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target, stall);
    end
    checks++;
    if ({s_wr_en, s_wr_tag_en, s_wr_idx, s_wr_tag} !== {2'b11, 2'd3, 14'h0004}) begin
      errors++;
      $display("FAIL static_tag_grant: got en=%b tagen=%b idx=%0d tag=%h, expected 1 1 3 0004",
               s_wr_en, s_wr_tag_en, s_wr_idx, s_wr_tag);
    end
    bht_req = 1'b0;
    step();
    checks++;
    if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target} !== {3'b101, 2'd2, 14'h0004, 16'h0040}) begin
      errors++;
      $display("FAIL after_tag_hold: got en=%b tagen=%b bhten=%b idx=%0d tag=%h tgt=%h, expected 1 0 1 2 0004 0040",
               wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target);
    end
    step();
    step();
    checks++;
    if ({wr_en, stall} !== 2'b00) begin
      errors++;
      $display("FAIL starve_drained: got en=%b stall=%b, expected 0 0", wr_en, stall);
    end
  endtask

  task automatic test_overflow();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tag_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tag_pc     = 16'h0013 + WS'(15 * i);
      tag_target = 16'h0040 * WS'(i + 1);
      step();
      checks++;
      if ({stall, overflow} !== {1'b1, (i == 2)}) begin
        errors++;
        $display("FAIL ovf_enqueue_%0d: got stall=%b ovf=%b, expected 1 %b", i, stall, overflow, (i == 2));
      end
    end
    tag_req = 1'b0;
    step();
    step();
    checks++;
    if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target, overflow}
        !== {3'b110, 2'd3, 14'h0004, 16'h0040, 1'b1}) begin
      errors++;
      $display("FAIL ovf_first_write: got en=%b tagen=%b bhten=%b idx=%0d tag=%h tgt=%h ovf=%b, expected 1 1 0 3 0004 0040 1",
               wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_tag, wr_target, overflow);
    end
    step();
    checks++;
    if ({wr_en, wr_tag_en, wr_idx, wr_tag, wr_target} !== {2'b11, 2'd2, 14'h0008, 16'h0080}) begin
      errors++;
      $display("FAIL ovf_second_write: got en=%b tagen=%b idx=%0d tag=%h tgt=%h, expected 1 1 2 0008 0080",
               wr_en, wr_tag_en, wr_idx, wr_tag, wr_target);
    end
    step();
    checks++;
    if ({wr_en, stall, overflow} !== 3'b001) begin
      errors++;
      $display("FAIL ovf_dropped_sticky: got en=%b stall=%b ovf=%b, expected 0 0 1", wr_en, stall, overflow);
    end
  endtask

  task automatic test_reset_mid_queue();
    reset = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared: got ovf=%b, expected 0", overflow);
    end
    reset   = 1'b0;
    bht_req = 1'b1;
    bht_pc  = 16'h0005;
    step();
    step();
    bht_req = 1'b0;
    checks++;
    if ({stall, rd_idx, wr_idx} !== {1'b1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL midq_loaded: got stall=%b rd_idx=%0d wr_idx=%0d, expected 1 1 1", stall, rd_idx, wr_idx);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, init_busy, stall} !== {3'b000, 2'd0, 2'b11}) begin
      errors++;
      $display("FAIL async_reset: got en=%b tagen=%b bhten=%b idx=%0d busy=%b stall=%b, expected 0 0 0 0 1 1",
               wr_en, wr_tag_en, wr_bht_en, wr_idx, init_busy, stall);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_bht} !== {3'b111, IDX_W'(k), 2'b10}) begin
        errors++;
        $display("FAIL resweep_%0d: got en=%b tagen=%b bhten=%b idx=%0d bht=%b, expected 1 1 1 %0d 10",
                 k, wr_en, wr_tag_en, wr_bht_en, wr_idx, wr_bht, k);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({wr_en, stall, init_busy} !== 3'b000) begin
        errors++;
        $display("FAIL no_stale_%0d: got en=%b stall=%b busy=%b, expected 0 0 0", k, wr_en, stall, init_busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_counter_modes();
    test_starvation();
    test_overflow();
    test_reset_mid_queue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
